// File: rtl/uart_rx_if.sv
// uart_rx_if -- register-side bundle of the UART receiver.
//   rx_en       receiver enable (low = abort and hold idle)
//   no_parity   1 = frame has no parity bit
//   ev_parity   parity sense when no_parity=0: 1 = even, 0 = odd
//   rxd_out     last received byte
//   rx_ok       one-clk pulse: frame completed, rxd_out and flags valid
//   parity_err  parity mismatch in the last frame
//   frame_err   stop bit sampled low in the last frame
//   rx_busy     receiver is somewhere inside a frame
// master = register block, slave = receiver.
interface uart_rx_if;
  logic       rx_en;
  logic       no_parity;
  logic       ev_parity;
  logic [7:0] rxd_out;
  logic       rx_ok;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_en, no_parity, ev_parity,
    input  rxd_out, rx_ok, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx_en, no_parity, ev_parity,
    output rxd_out, rx_ok, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 16x oversampling UART receiver, 1 start, 8 data (LSB first),
// optional even/odd parity, 1 stop bit.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   baud16_clk  level signal at 16x baud; its rising edge is the sample tick
//   rxd         asynchronous serial line, idles high
//   rif         register-side bundle (enable, format, received byte, status)
module uart_rx (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      baud16_clk,
  input  logic      rxd,
  uart_rx_if.slave  rif
);

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  logic       rxd_s1, rxd_s2;
  logic       baud16_d;
  logic       tick;
  logic       line;

  logic [2:0] state;
  logic [3:0] samp_cnt;
  logic [2:0] bit_cnt;
  logic       line_prev;
  logic [7:0] shift_q;
  logic       np_q;        // no_parity latched for the current frame
  logic       ev_q;        // ev_parity latched for the current frame
  logic       par_err_q;   // parity error pending until the stop bit

  logic [7:0] rxd_out_q;
  logic       rx_ok_q;
  logic       parity_err_q;
  logic       frame_err_q;

  // Line synchronizer and tick edge detector. Reset values keep the line
  // looking idle and avoid a spurious tick straight out of reset.
  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample the pre-edge values; blocking here would collapse the 2-flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      baud16_d <= 1'b0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      baud16_d <= baud16_clk;
    end
  end

  assign tick = baud16_clk & ~baud16_d;
  assign line = rxd_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RX_IDLE;
      samp_cnt     <= 4'd0;
      bit_cnt      <= 3'd0;
      line_prev    <= 1'b1;
      shift_q      <= 8'h00;
      np_q         <= 1'b1;
      ev_q         <= 1'b0;
      par_err_q    <= 1'b0;
      rxd_out_q    <= 8'h00;
      rx_ok_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_ok_q <= 1'b0;
      if (!rif.rx_en) begin
        // Abort: drop any frame in progress; delivered status is untouched.
        state     <= RX_IDLE;
        samp_cnt  <= 4'd0;
        bit_cnt   <= 3'd0;
        line_prev <= 1'b1;
      end else if (tick) begin
        line_prev <= line;
        case (state)
          RX_IDLE: begin
            // Edge rather than level: a held-low (break) line cannot
            // retrigger until it has gone high again.
            if (!line && line_prev) begin
              state    <= RX_START;
              samp_cnt <= 4'd0;
            end
          end

          RX_START: begin
            if (samp_cnt == 4'd7) begin
              if (!line) begin
                state    <= RX_DATA;
                samp_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
                np_q     <= rif.no_parity;
                ev_q     <= rif.ev_parity;
              end else begin
                state <= RX_IDLE;   // false start, glitch on the line
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end

          RX_DATA: begin
            samp_cnt <= samp_cnt + 4'd1;   // wraps 15 -> 0 at each bit centre
            if (samp_cnt == 4'd15) begin
              shift_q <= {line, shift_q[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= np_q ? RX_STOP : RX_PARITY;
              end
            end
          end

          RX_PARITY: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              par_err_q <= (line != (ev_q ? ^shift_q : ~^shift_q));
              state     <= RX_STOP;
            end
          end

          RX_STOP: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              // The byte is delivered even with a bad stop bit.
              rxd_out_q    <= shift_q;
              parity_err_q <= ~np_q & par_err_q;
              frame_err_q  <= ~line;
              rx_ok_q      <= 1'b1;
              state        <= RX_IDLE;
            end
          end

          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  assign rif.rxd_out    = rxd_out_q;
  assign rif.rx_ok      = rx_ok_q;
  assign rif.parity_err = parity_err_q;
  assign rif.frame_err  = frame_err_q;
  assign rif.rx_busy    = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx. Stimulus pushes the expected
// byte/flags of each frame it sends; a monitor pops on every rx_ok.
module tb_uart_rx;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic baud16_clk = 1'b0;
  logic rxd        = 1'b1;

  uart_rx_if rif ();

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud16_clk (baud16_clk),
    .rxd        (rxd),
    .rif        (rif)
  );

  // 4 clk per tick, 64 clk per bit.
  always #5  clk        = ~clk;
  always #20 baud16_clk = ~baud16_clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       sb[$];
  int         checks     = 0;
  int         errors     = 0;
  int         rx_ok_seen = 0;
  int         exp_frames = 0;
  int         hold_viol  = 0;
  logic [7:0] held_data  = 8'h00;
  logic       held_perr  = 1'b0;
  logic       held_ferr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: parity bit a correct transmitter would send.
  function automatic logic good_parity(input logic [7:0] b, input logic even);
    int ones;
    ones = $countones(b);
    return even ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rif.rx_ok === 1'b1) begin
        rx_ok_seen++;
        if (sb.size() == 0) begin
          check("unexpected_rx_ok_queue_size", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("rxd_out",    rif.rxd_out,    e.data);
          check("parity_err", rif.parity_err, e.perr);
          check("frame_err",  rif.frame_err,  e.ferr);
          held_data = e.data;
          held_perr = e.perr;
          held_ferr = e.ferr;
        end
      end else if (rif.rxd_out !== held_data || rif.parity_err !== held_perr ||
                   rif.frame_err !== held_ferr || rif.rx_ok !== 1'b0) begin
        hold_viol++;
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge baud16_clk);
  endtask

  // Sends one frame; the format used by the model is the one set before the
  // start bit. scramble perturbs the format inputs mid-frame.
  task automatic send_frame(input logic [7:0] b, input bit use_par, input bit even,
                            input bit par_bit, input bit stop, input bit scramble);
    exp_t e;
    e.data = b;
    e.perr = use_par ? logic'(par_bit != good_parity(b, even)) : 1'b0;
    e.ferr = ~stop;
    sb.push_back(e);
    exp_frames++;
    rif.no_parity = ~use_par;
    rif.ev_parity = even;
    rxd = 1'b0;
    wait_ticks(16);
    if (scramble) begin
      rif.no_parity = 1'($urandom);
      rif.ev_parity = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(16);
    end
    if (use_par) begin
      rxd = par_bit;
      wait_ticks(16);
    end
    rxd = stop;
    wait_ticks(16);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    int base;
    logic [7:0] b;
    bit up, ev, pb, st;

    rif.rx_en     = 1'b1;
    rif.no_parity = 1'b1;
    rif.ev_parity = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rxd_out",    rif.rxd_out,    8'h00);
    check("rst_rx_ok",      rif.rx_ok,      0);
    check("rst_parity_err", rif.parity_err, 0);
    check("rst_frame_err",  rif.frame_err,  0);
    check("rst_rx_busy",    rif.rx_busy,    0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 0, 0, 0, 1, 0);
    drain("drain_8n1");
    wait_ticks(2);
    @(negedge clk);
    check("busy_after_8n1", rif.rx_busy, 0);

    // 8E1 0x3C, correct then wrong parity
    send_frame(8'h3C, 1, 1, 0, 1, 0);
    send_frame(8'h3C, 1, 1, 1, 1, 0);
    // 8O1 0x01, wrong parity bit
    send_frame(8'h01, 1, 0, 1, 1, 0);
    drain("drain_parity");

    // Break: 0x55 with stop low, then 40 bit times low
    wait_ticks(3);
    base = rx_ok_seen;
    send_frame(8'h55, 0, 0, 0, 0, 0);
    wait_ticks(40 * 16);
    drain("drain_break");
    check("break_single_rx_ok", rx_ok_seen - base, 1);
    rxd = 1'b1;
    wait_ticks(4);
    send_frame(8'h5A, 0, 0, 0, 1, 0);
    drain("drain_after_break");
    check("after_break_rx_ok", rx_ok_seen - base, 2);

    // Glitch: 4 ticks low
    wait_ticks(3);
    base = rx_ok_seen;
    rxd = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    check("glitch_busy_high", rif.rx_busy, 1);
    rxd = 1'b1;
    wait_ticks(12);
    @(negedge clk);
    check("glitch_busy_low", rif.rx_busy, 0);
    wait_ticks(32);
    check("glitch_no_rx_ok", rx_ok_seen - base, 0);

    // Abort after data bit 3
    base = rx_ok_seen;
    rif.no_parity = 1'b1;
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'(8'h9C >> i);
      wait_ticks(16);
    end
    @(negedge clk);
    rif.rx_en = 1'b0;
    @(negedge clk);
    check("abort_busy_low", rif.rx_busy, 0);
    rxd = 1'b1;
    wait_ticks(120);
    @(negedge clk);
    check("abort_no_rx_ok", rx_ok_seen - base, 0);
    check("abort_rxd_out_held", rif.rxd_out, 8'h5A);
    rif.rx_en = 1'b1;
    wait_ticks(4);
    send_frame(8'h12, 0, 0, 0, 1, 0);
    send_frame(8'h34, 0, 0, 0, 1, 0);
    drain("drain_b2b");
    check("b2b_rx_ok_count", rx_ok_seen - base, 2);

    // Randomized frames, some with bad parity / stop and mid-frame format noise
    for (int n = 0; n < 20; n++) begin
      b  = 8'($urandom);
      up = 1'($urandom);
      ev = 1'($urandom);
      pb = good_parity(b, ev) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) != 0);
      send_frame(b, up, ev, pb, st, 1'($urandom));
      if (!st) begin
        rxd = 1'b1;
        wait_ticks($urandom_range(2, 6));
      end else if ($urandom_range(0, 1) == 1) begin
        wait_ticks($urandom_range(1, 10));
      end
    end
    drain("drain_random");
    wait_ticks(20);
    @(negedge clk);
    check("final_busy", rif.rx_busy, 0);
    check("total_rx_ok", rx_ok_seen, exp_frames);
    check("status_hold", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #5ms;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
